// File: rtl/boid_frame_writer_pkg.sv
// Shared boids definitions: video geometry, pixel address width, boid count and
// the frame writer state encoding, used by the VGA controller, BPUs and writer.
package boid_frame_writer_pkg;

    localparam int DEF_VIDEO_WIDTH  = 640;
    localparam int DEF_VIDEO_HEIGHT = 480;
    localparam int DEF_ADDR_WIDTH   = 19;
    localparam int DEF_MAX_BOIDS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWAP   = 3'd1,
        ST_SCAN   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } frame_state_t;

endpackage

// File: rtl/boid_frame_writer_pixel_addr_calc.sv
// Combinational pixel address (x + 640*y, built from shifts) and on-screen check,
// shared by the frame writer and the VGA read side.
module pixel_addr_calc
    import boid_frame_writer_pkg::*;
#(
    parameter int VIDEO_WIDTH  = DEF_VIDEO_WIDTH,
    parameter int VIDEO_HEIGHT = DEF_VIDEO_HEIGHT,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
    input  logic [9:0]            x,
    input  logic [8:0]            y,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  in_bounds
);

    localparam logic [9:0] X_LIMIT = 10'(VIDEO_WIDTH);
    localparam logic [8:0] Y_LIMIT = 9'(VIDEO_HEIGHT);

    // 640*y = 512*y + 128*y, so no multiplier is needed
    assign addr = (ADDR_WIDTH'(y) << 9) + (ADDR_WIDTH'(y) << 7) + ADDR_WIDTH'(x);

    assign in_bounds = (x < X_LIMIT) && (y < Y_LIMIT);

endmodule

// File: rtl/boid_frame_writer.sv
// Per-frame boid plotter: on frame_end, swaps display buffers, scans every BPU
// through boid_sel and issues one registered pixel write per on-screen boid.
module boid_frame_writer
    import boid_frame_writer_pkg::*;
#(
    parameter int MAX_BOIDS    = DEF_MAX_BOIDS,
    parameter int VIDEO_WIDTH  = DEF_VIDEO_WIDTH,
    parameter int VIDEO_HEIGHT = DEF_VIDEO_HEIGHT,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         frame_end,
    output logic [$clog2(MAX_BOIDS)-1:0] boid_sel,
    input  logic [9:0]                   x_loc,
    input  logic [8:0]                   y_loc,
    output logic                         wr_en,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic                         wr_data,
    output logic                         buf_swap,
    output logic                         write_buf,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   skip_count,
    output logic [7:0]                   overrun_count
);

    localparam int SEL_W = $clog2(MAX_BOIDS);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(MAX_BOIDS - 1);

    frame_state_t          state;
    frame_state_t          next_state;
    logic [SEL_W-1:0]      sel_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  write_buf_q;
    logic [7:0]            skip_q;
    logic [7:0]            overrun_q;
    logic [ADDR_WIDTH-1:0] pix_addr;
    logic                  pix_in_bounds;

    pixel_addr_calc #(
        .VIDEO_WIDTH  (VIDEO_WIDTH),
        .VIDEO_HEIGHT (VIDEO_HEIGHT),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_addr_calc (
        .x         (x_loc),
        .y         (y_loc),
        .addr      (pix_addr),
        .in_bounds (pix_in_bounds)
    );

    // Boid position is registered each SCAN cycle, so its write lands one cycle later
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            sel_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            write_buf_q <= 1'b0;
            skip_q      <= 8'd0;
            overrun_q   <= 8'd0;
        end else begin
            state <= next_state;
            if (next_state == ST_SWAP) begin
                write_buf_q <= ~write_buf_q;
            end
            if (state == ST_SCAN) begin
                sel_q <= sel_q + 1'b1;
            end else begin
                sel_q <= '0;
            end
            wr_en_q <= (state == ST_SCAN) && pix_in_bounds;
            if ((state == ST_SCAN) && pix_in_bounds) begin
                wr_addr_q <= pix_addr;
            end
            if ((state == ST_SCAN) && !pix_in_bounds && (skip_q != 8'hFF)) begin
                skip_q <= skip_q + 8'd1;
            end
            if (frame_end && (state != ST_IDLE) && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (frame_end) next_state = ST_SWAP;
            ST_SWAP:   next_state = ST_SCAN;
            ST_SCAN:   if (sel_q == LAST_SEL) next_state = ST_DRAIN;
            ST_DRAIN:  next_state = ST_FINISH;
            ST_FINISH: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        buf_swap      = (state == ST_SWAP);
        busy          = (state != ST_IDLE);
        done          = (state == ST_FINISH);
        wr_data       = 1'b1;
        boid_sel      = sel_q;
        wr_en         = wr_en_q;
        wr_addr       = wr_addr_q;
        write_buf     = write_buf_q;
        skip_count    = skip_q;
        overrun_count = overrun_q;
    end

endmodule

// File: tb/tb_boid_frame_writer.sv
// Scoreboard bench for boid_frame_writer: stimulus queues expected swap/write/done
// events with their cycle numbers, a negedge monitor pops and compares them.
module tb_boid_frame_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_end;
    logic [2:0]  boid_sel;
    logic [9:0]  x_loc;
    logic [8:0]  y_loc;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic        wr_data;
    logic        buf_swap;
    logic        write_buf;
    logic        busy;
    logic        done;
    logic [7:0]  skip_count;
    logic [7:0]  overrun_count;

    logic [9:0]  bx [8];
    logic [8:0]  by [8];

    typedef struct {
        int kind;
        int cyc;
        int data;
    } event_t;

    event_t exp_q[$];
    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;
    bit     exp_wb = 1'b0;

    boid_frame_writer dut (
        .clock         (clock),
        .reset         (reset),
        .frame_end     (frame_end),
        .boid_sel      (boid_sel),
        .x_loc         (x_loc),
        .y_loc         (y_loc),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .buf_swap      (buf_swap),
        .write_buf     (write_buf),
        .busy          (busy),
        .done          (done),
        .skip_count    (skip_count),
        .overrun_count (overrun_count)
    );

    assign x_loc = bx[boid_sel];
    assign y_loc = by[boid_sel];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic observe(input int kind, input int data);
        event_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_event: got kind %0d data %0d at cycle %0d, expected none", kind, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.data != data) begin
                failures++;
                $display("[TB] FAIL event: got kind %0d cycle %0d data %0d, expected kind %0d cycle %0d data %0d",
                         kind, cyc, data, e.kind, e.cyc, e.data);
            end
        end
    endtask

    // kinds: 0 = buf_swap (data = write_buf), 1 = write (data = address), 2 = done
    always @(negedge clock) begin
        if (buf_swap === 1'b1) observe(0, int'(write_buf));
        if (wr_en === 1'b1)    observe(1, int'(wr_addr));
        if (done === 1'b1)     observe(2, 0);
    end

    task automatic pushFrame(input int c0);
        event_t e;
        exp_wb = ~exp_wb;
        e = '{kind: 0, cyc: c0 + 1, data: int'(exp_wb)};
        exp_q.push_back(e);
        for (int k = 0; k < 8; k++) begin
            if (bx[k] < 10'd640 && by[k] < 9'd480) begin
                e = '{kind: 1, cyc: c0 + 3 + k, data: int'(by[k]) * 640 + int'(bx[k])};
                exp_q.push_back(e);
            end
        end
        e = '{kind: 2, cyc: c0 + 11, data: 0};
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input bit expect_frame);
        @(posedge clock);
        #1 frame_end = 1'b1;
        if (expect_frame) pushFrame(cyc);
        @(posedge clock);
        #1 frame_end = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic setDefaultBoids();
        for (int i = 0; i < 8; i++) begin
            bx[i] = 10'(i * 10);
            by[i] = 9'(i * 5);
        end
    endtask

    initial begin
        event_t e;
        int c0;
        reset     = 1'b1;
        frame_end = 1'b0;
        setDefaultBoids();

        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_wr_en", int'(wr_en), 0);
        checkOutput("reset_wr_addr", int'(wr_addr), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_write_buf", int'(write_buf), 0);
        checkOutput("reset_boid_sel", int'(boid_sel), 0);
        checkOutput("reset_skip", int'(skip_count), 0);
        checkOutput("reset_wr_data", int'(wr_data), 1);
        reset = 1'b0;

        // single frame: writes at i*3210
        applyStimulus(1'b1);
        waitCycles(11);
        checkOutput("frame1_busy", int'(busy), 0);
        checkOutput("frame1_write_buf", int'(write_buf), 1);
        checkOutput("frame1_last_addr", int'(wr_addr), 22470);

        // bounds: corner pixel written, two off-screen boids skipped
        bx[3] = 10'd639; by[3] = 9'd479;
        bx[4] = 10'd640; by[4] = 9'd0;
        bx[5] = 10'd0;   by[5] = 9'd480;
        applyStimulus(1'b1);
        waitCycles(11);
        checkOutput("bounds_skip", int'(skip_count), 2);
        checkOutput("bounds_write_buf", int'(write_buf), 0);
        setDefaultBoids();

        // overrun: second frame_end three cycles into the frame
        applyStimulus(1'b1);
        waitCycles(1);
        applyStimulus(1'b0);
        waitCycles(8);
        checkOutput("overrun_count", int'(overrun_count), 1);
        checkOutput("overrun_busy", int'(busy), 0);
        applyStimulus(1'b1);
        waitCycles(11);
        checkOutput("overrun_next_write_buf", int'(write_buf), 0);

        // back-to-back: each frame_end lands on the first IDLE cycle
        for (int f = 0; f < 4; f++) begin
            applyStimulus(1'b1);
            waitCycles(10);
        end
        waitCycles(1);
        checkOutput("b2b_overrun", int'(overrun_count), 1);
        checkOutput("b2b_busy", int'(busy), 0);

        // reset mid-SCAN while boid 4 is selected
        @(posedge clock);
        #1 frame_end = 1'b1;
        c0 = cyc;
        exp_wb = ~exp_wb;
        e = '{kind: 0, cyc: c0 + 1, data: int'(exp_wb)};
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            e = '{kind: 1, cyc: c0 + 3 + k, data: k * 3210};
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1 frame_end = 1'b0;
        waitCycles(5);
        checkOutput("abort_boid_sel", int'(boid_sel), 4);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_wr_en", int'(wr_en), 0);
        checkOutput("abort_wr_addr", int'(wr_addr), 0);
        checkOutput("abort_boid_sel_zero", int'(boid_sel), 0);
        checkOutput("abort_write_buf", int'(write_buf), 0);
        checkOutput("abort_skip", int'(skip_count), 0);
        checkOutput("abort_overrun", int'(overrun_count), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_buf_swap", int'(buf_swap), 0);
        reset  = 1'b0;
        exp_wb = 1'b0;
        waitCycles(15);
        checkOutput("abort_queue_empty", exp_q.size(), 0);

        // saturation: one boid off-screen every frame
        bx[6] = 10'd700; by[6] = 9'd10;
        for (int f = 1; f <= 300; f++) begin
            applyStimulus(1'b1);
            waitCycles(10);
            if (f == 200) checkOutput("skip_at_200", int'(skip_count), 200);
        end
        waitCycles(2);
        checkOutput("skip_saturated", int'(skip_count), 255);
        checkOutput("sat_overrun", int'(overrun_count), 0);
        checkOutput("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
